// File: rtl/wb_arbiter_rr.sv
// Round-robin Wishbone B3 arbiter: one shared slave port, ownership held for a whole
// CYC assertion, with a per-strobe watchdog that terminates stalled transfers with ERR.
module wb_arbiter_rr #(
  parameter int masters = 3,
  parameter int timeout = 255,
  parameter int ADR_W   = 32,
  parameter int DATA_W  = 32
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic [masters-1:0][ADR_W-1:0]     master_adr,
  input  logic [masters-1:0][DATA_W-1:0]    master_dat_m2s,
  input  logic [masters-1:0][DATA_W/8-1:0]  master_sel,
  input  logic [masters-1:0]                master_we,
  input  logic [masters-1:0]                master_cyc,
  input  logic [masters-1:0]                master_stb,
  input  logic [masters-1:0][2:0]           master_cti,
  input  logic [masters-1:0][1:0]           master_bte,
  output logic [masters-1:0][DATA_W-1:0]    master_dat_s2m,
  output logic [masters-1:0]                master_ack,
  output logic [masters-1:0]                master_err,
  output logic [masters-1:0]                master_rty,
  output logic [ADR_W-1:0]                  slave_adr,
  output logic [DATA_W-1:0]                 slave_dat_m2s,
  output logic [DATA_W/8-1:0]               slave_sel,
  output logic                              slave_we,
  output logic                              slave_cyc,
  output logic                              slave_stb,
  output logic [2:0]                        slave_cti,
  output logic [1:0]                        slave_bte,
  input  logic [DATA_W-1:0]                 slave_dat_s2m,
  input  logic                              slave_ack,
  input  logic                              slave_err,
  input  logic                              slave_rty,
  output logic [masters-1:0]                gnt,
  output logic                              tout
);

  localparam int OW = $clog2(masters);
  localparam int CW = (timeout > 0) ? $clog2(timeout + 1) : 1;

  typedef enum logic {IDLE, OWN} state_t;

  state_t        state;
  logic [OW-1:0] owner;
  logic [OW-1:0] last;
  logic [CW-1:0] cnt;

  logic [OW-1:0] pick;
  logic [OW:0]   cand;
  logic          any_req;
  logic          own_cyc;
  logic          own_stb;
  logic          resp;
  logic          fire;

  // First requester after the previous owner, wrapping; lowest offset wins.
  always_comb begin
    pick    = '0;
    cand    = '0;
    any_req = |master_cyc;
    for (int k = masters; k >= 1; k--) begin
      cand = {1'b0, last} + (OW+1)'(k);
      if (cand >= (OW+1)'(masters)) cand = cand - (OW+1)'(masters);
      if (master_cyc[cand[OW-1:0]]) pick = cand[OW-1:0];
    end
  end

  assign own_cyc = (state == OWN) && master_cyc[owner];
  assign own_stb = (state == OWN) && master_stb[owner];
  assign resp    = slave_ack | slave_err | slave_rty;
  assign fire    = (timeout > 0) && own_stb && !resp && (cnt == CW'(timeout));
  assign tout    = fire;

  // Data path is combinational; a watchdog hit masks the strobe and forges ERR.
  always_comb begin
    slave_adr      = '0;
    slave_dat_m2s  = '0;
    slave_sel      = '0;
    slave_we       = 1'b0;
    slave_cyc      = 1'b0;
    slave_stb      = 1'b0;
    slave_cti      = '0;
    slave_bte      = '0;
    master_dat_s2m = '0;
    master_ack     = '0;
    master_err     = '0;
    master_rty     = '0;
    if (state == OWN) begin
      slave_adr             = master_adr[owner];
      slave_dat_m2s         = master_dat_m2s[owner];
      slave_sel             = master_sel[owner];
      slave_we              = master_we[owner];
      slave_cyc             = own_cyc & ~fire;
      slave_stb             = own_stb & ~fire;
      slave_cti             = master_cti[owner];
      slave_bte             = master_bte[owner];
      master_dat_s2m[owner] = fire ? '0 : slave_dat_s2m;
      master_ack[owner]     = slave_ack & ~fire;
      master_err[owner]     = slave_err | fire;
      master_rty[owner]     = slave_rty & ~fire;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      owner <= '0;
      last  <= OW'(masters - 1);
      cnt   <= '0;
      gnt   <= '0;
    end else begin
      case (state)
        IDLE: begin
          cnt <= '0;
          if (any_req) begin
            owner <= pick;
            gnt   <= masters'(1) << pick;
            state <= OWN;
          end
        end
        OWN: begin
          if (!master_cyc[owner]) begin
            last  <= owner;
            cnt   <= '0;
            gnt   <= '0;
            state <= IDLE;
          end else if ((timeout > 0) && own_stb && !resp && !fire) begin
            cnt <= cnt + 1'b1;
          end else begin
            cnt <= '0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_wb_arbiter_rr.sv
// Bench for wb_arbiter_rr: vector table, hand-written corner sequences and a
// randomized run against a cycle-level reference model.
module tb_wb_arbiter_rr;
  localparam int M  = 3;
  localparam int TO = 4;
  localparam int AW = 32;
  localparam int DW = 32;

  logic                   clk = 1'b0;
  logic                   rst_n = 1'b0;
  logic [M-1:0][AW-1:0]   master_adr;
  logic [M-1:0][DW-1:0]   master_dat_m2s;
  logic [M-1:0][DW/8-1:0] master_sel;
  logic [M-1:0]           master_we;
  logic [M-1:0]           master_cyc;
  logic [M-1:0]           master_stb;
  logic [M-1:0][2:0]      master_cti;
  logic [M-1:0][1:0]      master_bte;
  logic [M-1:0][DW-1:0]   master_dat_s2m;
  logic [M-1:0]           master_ack;
  logic [M-1:0]           master_err;
  logic [M-1:0]           master_rty;
  logic [AW-1:0]          slave_adr;
  logic [DW-1:0]          slave_dat_m2s;
  logic [DW/8-1:0]        slave_sel;
  logic                   slave_we;
  logic                   slave_cyc;
  logic                   slave_stb;
  logic [2:0]             slave_cti;
  logic [1:0]             slave_bte;
  logic [DW-1:0]          slave_dat_s2m;
  logic                   slave_ack;
  logic                   slave_err;
  logic                   slave_rty;
  logic [M-1:0]           gnt;
  logic                   tout;

  always #5 clk = ~clk;

  wb_arbiter_rr #(.masters(M), .timeout(TO), .ADR_W(AW), .DATA_W(DW)) dut (
    .clk(clk), .rst_n(rst_n),
    .master_adr(master_adr), .master_dat_m2s(master_dat_m2s), .master_sel(master_sel),
    .master_we(master_we), .master_cyc(master_cyc), .master_stb(master_stb),
    .master_cti(master_cti), .master_bte(master_bte),
    .master_dat_s2m(master_dat_s2m), .master_ack(master_ack), .master_err(master_err),
    .master_rty(master_rty),
    .slave_adr(slave_adr), .slave_dat_m2s(slave_dat_m2s), .slave_sel(slave_sel),
    .slave_we(slave_we), .slave_cyc(slave_cyc), .slave_stb(slave_stb),
    .slave_cti(slave_cti), .slave_bte(slave_bte),
    .slave_dat_s2m(slave_dat_s2m), .slave_ack(slave_ack), .slave_err(slave_err),
    .slave_rty(slave_rty),
    .gnt(gnt), .tout(tout)
  );

  int n_pass  = 0;
  int n_total = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  typedef struct {
    logic [2:0] cyc;
    logic [2:0] stb;
    logic       sack;
    logic [2:0] gnt;
    logic       scyc;
    logic [2:0] mack;
  } vec_t;

  vec_t tbl[22];

  // Reference model state: owner (-1 = bus idle), previous owner, unanswered strobe count.
  int m_own, m_last, m_wait;

  initial begin
    for (int i = 0; i < M; i++) begin
      master_adr[i]     = 32'h1000_0000 + 32'(i) * 32'h100;
      master_dat_m2s[i] = 32'hA000_0000 + 32'(i);
      master_sel[i]     = 4'hF;
      master_we[i]      = 1'b0;
      master_cti[i]     = 3'b000;
      master_bte[i]     = 2'b00;
    end
    master_cti[1] = 3'b010;
    master_cyc    = '0;
    master_stb    = '0;
    slave_dat_s2m = '0;
    slave_ack     = 1'b0;
    slave_err     = 1'b0;
    slave_rty     = 1'b0;

    //          cyc     stb     ack   gnt     scyc  mack
    tbl[0]  = '{3'b111, 3'b000, 1'b0, 3'b000, 1'b0, 3'b000};
    tbl[1]  = '{3'b111, 3'b001, 1'b1, 3'b001, 1'b1, 3'b001};
    tbl[2]  = '{3'b110, 3'b000, 1'b0, 3'b001, 1'b0, 3'b000};
    tbl[3]  = '{3'b111, 3'b000, 1'b0, 3'b000, 1'b0, 3'b000};
    tbl[4]  = '{3'b111, 3'b010, 1'b1, 3'b010, 1'b1, 3'b010};
    tbl[5]  = '{3'b101, 3'b000, 1'b0, 3'b010, 1'b0, 3'b000};
    tbl[6]  = '{3'b111, 3'b000, 1'b0, 3'b000, 1'b0, 3'b000};
    tbl[7]  = '{3'b111, 3'b100, 1'b1, 3'b100, 1'b1, 3'b100};
    tbl[8]  = '{3'b011, 3'b000, 1'b0, 3'b100, 1'b0, 3'b000};
    tbl[9]  = '{3'b111, 3'b000, 1'b0, 3'b000, 1'b0, 3'b000};
    tbl[10] = '{3'b111, 3'b001, 1'b1, 3'b001, 1'b1, 3'b001};
    tbl[11] = '{3'b110, 3'b000, 1'b0, 3'b001, 1'b0, 3'b000};
    tbl[12] = '{3'b011, 3'b000, 1'b0, 3'b000, 1'b0, 3'b000};
    tbl[13] = '{3'b011, 3'b010, 1'b1, 3'b010, 1'b1, 3'b010};
    tbl[14] = '{3'b011, 3'b010, 1'b1, 3'b010, 1'b1, 3'b010};
    tbl[15] = '{3'b011, 3'b010, 1'b1, 3'b010, 1'b1, 3'b010};
    tbl[16] = '{3'b011, 3'b010, 1'b1, 3'b010, 1'b1, 3'b010};
    tbl[17] = '{3'b001, 3'b000, 1'b0, 3'b010, 1'b0, 3'b000};
    tbl[18] = '{3'b001, 3'b000, 1'b0, 3'b000, 1'b0, 3'b000};
    tbl[19] = '{3'b001, 3'b001, 1'b1, 3'b001, 1'b1, 3'b001};
    tbl[20] = '{3'b000, 3'b000, 1'b0, 3'b001, 1'b0, 3'b000};
    tbl[21] = '{3'b000, 3'b000, 1'b0, 3'b000, 1'b0, 3'b000};

    // Reset held with every master requesting
    master_cyc = 3'b111;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst gnt", 32'(gnt), 32'h0);
    check("rst slave_cyc", 32'(slave_cyc), 32'h0);
    check("rst master_ack", 32'(master_ack), 32'h0);
    check("rst tout", 32'(tout), 32'h0);
    rst_n = 1'b1;

    for (int i = 0; i < 22; i++) begin
      master_cyc = tbl[i].cyc;
      master_stb = tbl[i].stb;
      slave_ack  = tbl[i].sack;
      #1;
      check($sformatf("vec%0d gnt", i), 32'(gnt), 32'(tbl[i].gnt));
      check($sformatf("vec%0d slave_cyc", i), 32'(slave_cyc), 32'(tbl[i].scyc));
      check($sformatf("vec%0d master_ack", i), 32'(master_ack), 32'(tbl[i].mack));
      if (tbl[i].gnt == 3'b010)
        check($sformatf("vec%0d slave_cti", i), 32'(slave_cti), 32'h2);
      @(negedge clk);
    end

    // Watchdog: master 1 strobes, slave never answers
    master_cyc = 3'b010;
    master_stb = 3'b000;
    slave_ack  = 1'b0;
    @(negedge clk);
    for (int k = 0; k <= TO; k++) begin
      master_stb = 3'b010;
      #1;
      check($sformatf("wd%0d err", k), 32'(master_err), (k == TO) ? 32'h2 : 32'h0);
      check($sformatf("wd%0d tout", k), 32'(tout), (k == TO) ? 32'h1 : 32'h0);
      check($sformatf("wd%0d slave_stb", k), 32'(slave_stb), (k == TO) ? 32'h0 : 32'h1);
      check($sformatf("wd%0d slave_cyc", k), 32'(slave_cyc), (k == TO) ? 32'h0 : 32'h1);
      @(negedge clk);
    end
    check("wd retained gnt", 32'(gnt), 32'h2);
    slave_ack = 1'b1;
    #1;
    check("wd after ack", 32'(master_ack), 32'h2);
    @(negedge clk);
    // Response arriving on the timeout cycle wins
    for (int k = 0; k <= TO; k++) begin
      slave_ack = (k == TO);
      #1;
      check($sformatf("wdr%0d tout", k), 32'(tout), 32'h0);
      check($sformatf("wdr%0d ack", k), 32'(master_ack), (k == TO) ? 32'h2 : 32'h0);
      check($sformatf("wdr%0d err", k), 32'(master_err), 32'h0);
      @(negedge clk);
    end
    master_cyc = 3'b000;
    master_stb = 3'b000;
    slave_ack  = 1'b0;
    @(negedge clk);

    // Isolation: master 2 owns, others keep requesting
    master_cyc = 3'b111;
    @(negedge clk);
    master_stb    = 3'b111;
    slave_ack     = 1'b1;
    slave_dat_s2m = 32'hDEADBEEF;
    #1;
    check("iso gnt", 32'(gnt), 32'h4);
    check("iso dat2", master_dat_s2m[2], 32'hDEADBEEF);
    check("iso dat1", master_dat_s2m[1], 32'h0);
    check("iso dat0", master_dat_s2m[0], 32'h0);
    check("iso ack", 32'(master_ack), 32'h4);
    check("iso adr", slave_adr, 32'h1000_0200);
    @(negedge clk);
    master_cyc    = 3'b000;
    master_stb    = 3'b000;
    slave_ack     = 1'b0;
    slave_dat_s2m = '0;
    @(negedge clk);

    // Asynchronous reset during an owned write by master 1
    master_cyc = 3'b010;
    @(negedge clk);
    master_stb   = 3'b010;
    master_we[1] = 1'b1;
    slave_ack    = 1'b1;
    #1;
    check("ar pre slave_cyc", 32'(slave_cyc), 32'h1);
    check("ar pre slave_we", 32'(slave_we), 32'h1);
    check("ar pre ack", 32'(master_ack), 32'h2);
    #2;
    rst_n = 1'b0;
    #1;
    check("ar slave_cyc", 32'(slave_cyc), 32'h0);
    check("ar slave_stb", 32'(slave_stb), 32'h0);
    check("ar gnt", 32'(gnt), 32'h0);
    check("ar ack", 32'(master_ack), 32'h0);
    @(negedge clk);
    master_cyc = 3'b011;
    rst_n      = 1'b1;
    #1;
    check("ar release gnt", 32'(gnt), 32'h0);
    @(negedge clk);
    #1;
    check("ar restart gnt", 32'(gnt), 32'h1);
    master_cyc   = 3'b000;
    master_stb   = 3'b000;
    master_we[1] = 1'b0;
    slave_ack    = 1'b0;
    @(negedge clk);

    // Randomized run against the reference model
    rst_n = 1'b0;
    @(negedge clk);
    rst_n  = 1'b1;
    m_own  = -1;
    m_last = M - 1;
    m_wait = 0;
    for (int s = 0; s < 800; s++) begin
      logic [M-1:0]         e_gnt, e_ack, e_err, e_rty;
      logic [M-1:0][DW-1:0] e_dat;
      logic                 e_cyc, e_stb, e_tout, r, f;
      logic [AW-1:0]        e_adr;
      logic [DW-1:0]        e_wdat;
      for (int i = 0; i < M; i++) begin
        master_cyc[i]     = ($urandom_range(0, 99) < 85);
        master_stb[i]     = ($urandom_range(0, 99) < 75);
        master_dat_m2s[i] = $urandom;
      end
      slave_ack     = ($urandom_range(0, 99) < 20);
      slave_err     = ($urandom_range(0, 99) < 4);
      slave_rty     = ($urandom_range(0, 99) < 4);
      slave_dat_s2m = $urandom;
      #1;
      e_gnt = '0; e_ack = '0; e_err = '0; e_rty = '0; e_dat = '0;
      e_cyc = 1'b0; e_stb = 1'b0; e_tout = 1'b0; e_adr = '0; e_wdat = '0;
      r = slave_ack | slave_err | slave_rty;
      f = 1'b0;
      if (m_own >= 0) begin
        f          = master_stb[m_own] && !r && (m_wait == TO);
        e_gnt      = 3'(1 << m_own);
        e_cyc      = master_cyc[m_own] && !f;
        e_stb      = master_stb[m_own] && !f;
        e_tout     = f;
        e_adr      = master_adr[m_own];
        e_wdat     = master_dat_m2s[m_own];
        e_ack      = f ? 3'b000 : 3'(slave_ack << m_own);
        e_err      = f ? 3'(1 << m_own) : 3'(slave_err << m_own);
        e_rty      = f ? 3'b000 : 3'(slave_rty << m_own);
        e_dat[m_own] = f ? '0 : slave_dat_s2m;
      end
      check($sformatf("rnd%0d gnt", s), 32'(gnt), 32'(e_gnt));
      check($sformatf("rnd%0d slave_cyc", s), 32'(slave_cyc), 32'(e_cyc));
      check($sformatf("rnd%0d slave_stb", s), 32'(slave_stb), 32'(e_stb));
      check($sformatf("rnd%0d slave_adr", s), slave_adr, e_adr);
      check($sformatf("rnd%0d slave_dat", s), slave_dat_m2s, e_wdat);
      check($sformatf("rnd%0d tout", s), 32'(tout), 32'(e_tout));
      check($sformatf("rnd%0d ack", s), 32'(master_ack), 32'(e_ack));
      check($sformatf("rnd%0d err", s), 32'(master_err), 32'(e_err));
      check($sformatf("rnd%0d rty", s), 32'(master_rty), 32'(e_rty));
      for (int i = 0; i < M; i++)
        check($sformatf("rnd%0d dat%0d", s, i), master_dat_s2m[i], e_dat[i]);
      // Advance the model by one clock
      if (m_own < 0) begin
        for (int k = 1; k <= M; k++) begin
          if (m_own < 0 && master_cyc[(m_last + k) % M]) m_own = (m_last + k) % M;
        end
        m_wait = 0;
      end else if (!master_cyc[m_own]) begin
        m_last = m_own;
        m_own  = -1;
        m_wait = 0;
      end else if (master_stb[m_own] && !r && !f) begin
        m_wait = m_wait + 1;
      end else begin
        m_wait = 0;
      end
      @(negedge clk);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/wb_arbiter_rr.md
# wb_arbiter_rr

Registered round-robin arbiter that shares one Wishbone B3 slave port among several Wishbone masters, replacing fixed-priority combinational selection on the shared system bus. Ownership is granted per bus cycle (held for the whole CYC assertion, so bursts and read-modify-write sequences are never split). A per-transfer watchdog terminates stalled transfers with ERR. It sits between the CPU/debug/DMA masters and the address-decoding expander.

## Interface
- masters, default 3: number of requesting masters, 2..8.
- timeout, default 255: wait cycles allowed per strobe before a forced ERR; 0 disables the watchdog.
- clk  input  1  system clock, all state on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- master[masters]  wishbone_b3.slave  interface array  requesting masters; index 0 is highest priority only after reset.
- slave  wishbone_b3.master  interface  shared downstream bus.
- gnt  output  masters  one-hot current owner; all zero when idle.
- tout  output  1  one-cycle pulse on a watchdog-forced ERR.

## Operation
- State machine, states IDLE and OWN. Registers: state, owner index, last index, wait counter of width $clog2(timeout+1) (minimum 1 bit).
- Reset: state=IDLE, owner=0, last=masters-1, counter=0. Outputs at reset: gnt=0, tout=0, every slave.* output 0, every master[i].dat_s2m/ack/err/rty 0.
- IDLE: slave outputs all 0, master responses all 0. If any master[i].cyc=1, select the first requester searching last+1, last+2, ... wrapping modulo masters; load owner, go to OWN. Otherwise stay.
- OWN: slave.adr/cyc/dat_m2s/sel/we/stb/cti/bte = master[owner] signals; master[owner].dat_s2m/ack/err/rty = slave signals; all non-owners see 0 on dat_s2m/ack/err/rty. gnt = one-hot(owner).
- OWN exit: master[owner].cyc=0 -> next state IDLE, last=owner, counter=0. Requests from other masters are not considered until IDLE.
- Watchdog (timeout>0, in OWN only): counter increments each cycle master[owner].stb=1 and slave.ack|err|rty=0; clears on any response, on stb=0, or on leaving OWN.
- Timeout event: counter==timeout, stb=1, no slave response this cycle -> that cycle slave.cyc=0 and slave.stb=0, master[owner].err=1, ack=0, rty=0, dat_s2m=0, tout=1; counter clears. Ownership retained; master decides whether to retry or drop CYC.
- Simultaneous: slave response on the counter==timeout cycle wins (response passed through, no ERR, no tout). Owner dropping CYC while other masters request: one IDLE cycle, then round-robin from last+1.
- Owner drops CYC with STB still high: treated as abandon, normal OWN exit.
- Non-owner cyc/stb never reach the slave.

## Timing
- Grant latency: request in IDLE at cycle n -> gnt and slave.cyc valid at cycle n+1 (registered state, combinational data path).
- Data path in OWN is combinational both directions: zero added latency for adr/stb or ack/dat_s2m.
- Minimum one IDLE cycle (slave.cyc=0) between consecutive owners, including the same master re-requesting.
- Forced ERR appears exactly timeout cycles after the first unanswered stb cycle (stb cycle index 0; ERR on index timeout).
- rst_n assertion mid-transfer: slave.cyc/stb and all master responses drop to 0 asynchronously, no waiting for clk; release of rst_n takes effect on the next clk edge.

## Test plan
- Reset: rst_n=0 with all cyc=1 -> gnt=0, slave.cyc=0, all master ack=0; release -> master 0 granted one cycle later (gnt=3'b001).
- Round robin: all three cyc held, each owner does one single-beat read then drops cyc -> grant order 0,1,2,0, each separated by exactly one slave.cyc=0 cycle.
- Burst hold: master 1 owns, 4-beat burst with cti=3'b010 while master 0 requests -> all 4 acks routed to master 1, master 0 gnt only after master 1 drops cyc.
- Watchdog: timeout=4, slave never acks -> master err=1 and tout=1 on 5th stb cycle (index 4), slave.stb=0 that cycle; ack on index 4 instead -> ack passed, tout=0.
- Isolation: master 2 owns, slave returns dat_s2m=32'hDEADBEEF with ack -> masters 0 and 1 see dat_s2m=0, ack=0.
- Async reset mid-transfer: rst_n pulled low between clk edges during an owned write -> slave.cyc and slave.stb go 0 before the next edge; after release, arbitration restarts from master 0.
